sprite_loader: RTL and testbench

SPRITE_LOADER -- requirements
Module: sprite_loader

---
 rtl/sprite_loader.sv | 189 ++++++++++++++++++
 tb/tb_sprite_loader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_loader.sv
// rtl/sprite_loader.sv - framed byte-stream sprite loader with vblank-gated commit into a 256x8 sprite RAM
// Optional feature macro: SPRITE_LOADER_CHECKSUM_EN (trailing XOR checksum byte per frame).
// Frame: A5, index(0..4), 32 payload bytes [, checksum]. RAM address = {index, row, half}.

module sprite_loader (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready,
   input  logic       vblank,
   input  logic [7:0] rd_addr,
   output logic [7:0] rd_bits,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [4:0] loaded_mask
);

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam logic [7:0] MAX_INDEX = 8'd4;
   localparam logic [4:0] LAST      = 5'd31;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INDEX,
      S_DATA,
      S_CHECK,
      S_COMMIT_WAIT,
      S_COMMIT
   } state_t;

   state_t     state;
   state_t     next_state;

   logic [7:0] sprite_ram [0:255];
   logic [7:0] staging    [0:31];
   logic [4:0] counter;
   logic [2:0] index;

   logic       accept;
   logic       ld_index;
   logic       cnt_inc;
   logic       stage_we;
   logic       ram_we;
   logic       err_set;
   logic       done_set;

`ifdef SPRITE_LOADER_CHECKSUM_EN
   logic [7:0] xor_sum;
`endif

   // The receiving states are exactly the ones that accept stream bytes.
   assign rx_ready = (state == S_IDLE) || (state == S_INDEX) ||
                     (state == S_DATA) || (state == S_CHECK);
   assign busy     = (state != S_IDLE);
   assign accept   = rx_valid && rx_ready;

   // Renderer read port behaves like a ROM: combinational, zero latency.
   assign rd_bits  = sprite_ram[rd_addr];

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and datapath control; a frame that finishes while vblank is
   // already high moves straight into the commit.
   always_comb begin
      next_state = state;
      ld_index   = 1'b0;
      cnt_inc    = 1'b0;
      stage_we   = 1'b0;
      ram_we     = 1'b0;
      err_set    = 1'b0;
      done_set   = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept && (rx_data == SYNC_BYTE)) begin
               next_state = S_INDEX;
            end
         end
         S_INDEX: begin
            if (accept) begin
               if (rx_data <= MAX_INDEX) begin
                  ld_index   = 1'b1;
                  next_state = S_DATA;
               end else begin
                  err_set    = 1'b1;
                  next_state = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               stage_we = 1'b1;
               cnt_inc  = 1'b1;
               if (counter == LAST) begin
`ifdef SPRITE_LOADER_CHECKSUM_EN
                  next_state = S_CHECK;
`else
                  next_state = vblank ? S_COMMIT : S_COMMIT_WAIT;
`endif
               end
            end
         end
`ifdef SPRITE_LOADER_CHECKSUM_EN
         S_CHECK: begin
            if (accept) begin
               if (rx_data == xor_sum) begin
                  next_state = vblank ? S_COMMIT : S_COMMIT_WAIT;
               end else begin
                  err_set    = 1'b1;
                  next_state = S_IDLE;
               end
            end
         end
`endif
         S_COMMIT_WAIT: begin
            if (vblank) begin
               next_state = S_COMMIT;
            end
         end
         S_COMMIT: begin
            // Runs to completion regardless of vblank once started.
            ram_we  = 1'b1;
            cnt_inc = 1'b1;
            if (counter == LAST) begin
               done_set   = 1'b1;
               next_state = S_IDLE;
            end
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // Counter, index, status pulses and loaded mask; counter wraps 31->0 only on leaving DATA or COMMIT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         counter     <= '0;
         index       <= '0;
         done        <= 1'b0;
         err         <= 1'b0;
         loaded_mask <= '0;
      end else begin
         done <= done_set;
         err  <= err_set;
         if (ld_index) begin
            index   <= rx_data[2:0];
            counter <= '0;
         end else if (cnt_inc) begin
            counter <= counter + 5'd1;
         end
         if (done_set) begin
            loaded_mask <= loaded_mask | (5'd1 << index);
         end
      end
   end

`ifdef SPRITE_LOADER_CHECKSUM_EN
   // Running XOR of the payload bytes, restarted when a new index is latched.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         xor_sum <= '0;
      end else if (ld_index) begin
         xor_sum <= '0;
      end else if (stage_we) begin
         xor_sum <= xor_sum ^ rx_data;
      end
   end
`endif

   // Storage arrays carry no reset so a reset mid-commit keeps bytes already written.
   always_ff @(posedge clk) begin
      if (stage_we) begin
         staging[counter] <= rx_data;
      end
      if (ram_we) begin
         sprite_ram[{index, counter}] <= staging[counter];
      end
   end

endmodule

// File: tb/tb_sprite_loader.sv
// tb/tb_sprite_loader.sv - self-checking bench for sprite_loader: vector table, corner sequences, random frames vs model

module tb_sprite_loader;

`ifdef SPRITE_LOADER_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   typedef logic [7:0] pay_t [32];

   typedef struct {
      int idx;
      int pmode;
      bit corrupt;
      bit vb;
      int gap;
      int junk;
      bit exp_err;
      bit exp_done;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       rx_ready;
   logic       vblank = 1'b1;
   logic [7:0] rd_addr = 8'h00;
   logic [7:0] rd_bits;
   logic       busy;
   logic       done;
   logic       err;
   logic [4:0] loaded_mask;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int done_cyc = -1;
   int err_cyc = -1;

   logic [7:0] model_ram   [256];
   bit         model_valid [256];
   logic [4:0] model_mask = 5'd0;

   vec_t vecs [8];

   sprite_loader dut (
      .clk         (clk),
      .reset       (reset),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .vblank      (vblank),
      .rd_addr     (rd_addr),
      .rd_bits     (rd_bits),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .loaded_mask (loaded_mask)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
      if (err === 1'b1) begin
         err_cnt = err_cnt + 1;
         err_cyc = cyc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic make_pay(input int mode, output pay_t p);
      for (int i = 0; i < 32; i++) begin
         case (mode)
            0: p[i] = i[7:0];
            1: p[i] = 8'hFF;
            3: p[i] = (i % 3 == 0) ? 8'hA5 : 8'($urandom);
            default: p[i] = 8'($urandom);
         endcase
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, output int acc);
      int n;
      n = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 200) begin
         tick();
         n++;
      end
      if (!rx_ready) chk("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
      acc = cyc;
      tick();
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      repeat (gap) tick();
   endtask

   task automatic sweep(input string nm);
      for (int a = 0; a < 256; a++) begin
         if (model_valid[a]) begin
            rd_addr = a[7:0];
            #1;
            chk($sformatf("%s_ram%02h", nm, a), {24'd0, rd_bits}, {24'd0, model_ram[a]});
         end
      end
   endtask

   task automatic run_frame(input int idx, input pay_t pay, input bit corrupt, input bit vb,
                            input int gap, input int junk, input bit exp_err, input bit exp_done,
                            input string nm);
      int acc, ref_c, d0, e0;
      logic [7:0] sum, jb;
      d0 = done_cnt;
      e0 = err_cnt;
      vblank = vb;
      for (int j = 0; j < junk; j++) begin
         jb = 8'($urandom);
         if (jb == 8'hA5) jb = 8'h11;
         send_byte(jb, gap, acc);
      end
      send_byte(8'hA5, gap, acc);
      send_byte(idx[7:0], gap, acc);
      if (idx <= 4) begin
         sum = 8'h00;
         for (int i = 0; i < 32; i++) begin
            sum = sum ^ pay[i];
            send_byte(pay[i], gap, acc);
         end
         if (CSUM) send_byte(sum ^ {7'd0, corrupt}, gap, acc);
      end
      ref_c = acc;
      if (exp_done && !vb) begin
         repeat (4) tick();
         chk({nm, "_wait_ready"}, {31'd0, rx_ready}, 32'd0);
         chk({nm, "_wait_busy"}, {31'd0, busy}, 32'd1);
         vblank = 1'b1;
         ref_c  = cyc;
      end
      repeat (40) tick();
      chk({nm, "_done_cnt"}, done_cnt - d0, {31'd0, exp_done});
      chk({nm, "_err_cnt"}, err_cnt - e0, {31'd0, exp_err});
      if (exp_done) chk({nm, "_done_lat"}, done_cyc - ref_c, 32'd33);
      if (exp_err) chk({nm, "_err_lat"}, err_cyc - ref_c, 32'd1);
      chk({nm, "_idle_busy"}, {31'd0, busy}, 32'd0);
      if (exp_done) begin
         for (int i = 0; i < 32; i++) begin
            model_ram[idx * 32 + i]   = pay[i];
            model_valid[idx * 32 + i] = 1'b1;
         end
         model_mask[idx] = 1'b1;
      end
      chk({nm, "_mask"}, {27'd0, loaded_mask}, {27'd0, model_mask});
      sweep(nm);
   endtask

   initial begin
      pay_t p;
      int   acc, idx;
      bit   corrupt, vb, ok;

      for (int a = 0; a < 256; a++) model_valid[a] = 1'b0;

      vecs[0] = '{0, 2, 1'b0, 1'b1, 0, 0, 1'b0, 1'b1};
      vecs[1] = '{2, 0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b1};
      vecs[2] = '{7, 2, 1'b0, 1'b1, 0, 0, 1'b1, 1'b0};
      vecs[3] = '{0, 1, 1'b1, 1'b1, 0, 0, CSUM, !CSUM};
      vecs[4] = '{1, 2, 1'b0, 1'b1, 1, 2, 1'b0, 1'b1};
      vecs[5] = '{4, 3, 1'b0, 1'b1, 0, 1, 1'b0, 1'b1};
      vecs[6] = '{5, 2, 1'b0, 1'b1, 0, 0, 1'b1, 1'b0};
      vecs[7] = '{3, 2, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1};

      repeat (3) tick();
      chk("rst_ready", {31'd0, rx_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;
      tick();
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_mask", {27'd0, loaded_mask}, 32'd0);
      chk("rst_ready2", {31'd0, rx_ready}, 32'd1);

      for (int v = 0; v < 8; v++) begin
         make_pay(vecs[v].pmode, p);
         run_frame(vecs[v].idx, p, vecs[v].corrupt, vecs[v].vb, vecs[v].gap, vecs[v].junk,
                   vecs[v].exp_err, vecs[v].exp_done, $sformatf("vec%0d", v));
      end

      // Reset while the commit of bitmap 3 is at counter 10.
      for (int i = 0; i < 32; i++) p[i] = ~model_ram[96 + i];
      vblank = 1'b1;
      send_byte(8'hA5, 0, acc);
      send_byte(8'h03, 0, acc);
      begin
         logic [7:0] s;
         s = 8'h00;
         for (int i = 0; i < 32; i++) begin
            s = s ^ p[i];
            send_byte(p[i], 0, acc);
         end
         if (CSUM) send_byte(s, 0, acc);
      end
      repeat (10) tick();
      chk("midrst_busy_pre", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_mask", {27'd0, loaded_mask}, 32'd0);
      chk("midrst_ready", {31'd0, rx_ready}, 32'd1);
      tick();
      reset = 1'b0;
      repeat (2) tick();
      chk("midrst_done", {31'd0, done}, 32'd0);
      for (int i = 0; i < 10; i++) model_ram[96 + i] = p[i];
      model_mask = 5'd0;
      sweep("midrst");

      for (int r = 0; r < 10; r++) begin
         idx     = $urandom_range(0, 5);
         corrupt = CSUM && ($urandom_range(0, 3) == 0);
         vb      = $urandom_range(0, 1) == 1;
         ok      = (idx <= 4) && !corrupt;
         make_pay(($urandom_range(0, 1) == 1) ? 3 : 2, p);
         run_frame(idx, p, corrupt, vb, $urandom_range(0, 2), $urandom_range(0, 2),
                   !ok, ok, $sformatf("rnd%0d", r));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
